// File: rtl/px_recirculator_pkg.sv
// Shared draw header: pixel-word layout, escape marker, default frame size
// and draw-mode constants used by the recirculator and the display path.
package px_recirculator_pkg;

   localparam int PX_W         = 104;
   localparam int PX_VAL_MSB   = 103;
   localparam int PX_VAL_LSB   = 96;
   localparam int PX_X_LSB     = 64;
   localparam int PX_Y_LSB     = 32;
   localparam int PX_FIELD_W   = 32;

   localparam logic [31:0] ESC_MARK = 32'hFFFF_FFFF;

   localparam int DEF_H_PIXELS = 800;
   localparam int DEF_V_PIXELS = 480;

   localparam int DISP_X_W     = 10;
   localparam int DISP_Y_W     = 9;
   localparam int CNT_W        = 19;
   localparam int FRAME_W      = 16;

   typedef enum logic [1:0] {
      DRAW_MANDEL  = 2'd0,
      DRAW_JULIA   = 2'd1,
      DRAW_BURNING = 2'd2
   } draw_mode_e;

   typedef enum logic {
      ST_SEED = 1'b0,
      ST_RUN  = 1'b1
   } rec_state_e;

   // Same bit layout as the FIFO word, MSB first.
   typedef struct packed {
      logic [7:0]  val;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] iter;
   } px_word_t;

   function automatic logic px_escaped(input logic [31:0] x, input logic [31:0] y);
      return (x == ESC_MARK) && (y == ESC_MARK);
   endfunction

endpackage

// File: rtl/px_raster_counter.sv
// Raster position counter: X advances on enable, wraps into Y, Y wraps to 0.
// Wrap flags are combinational "at last column/row" indicators.
module px_raster_counter #(
   parameter int H_PIXELS = 800,
   parameter int V_PIXELS = 480,
   parameter int XW       = 10,
   parameter int YW       = 9
) (
   input  logic          i_Clk,
   input  logic          i_Rst_n,
   input  logic          clr,
   input  logic          en,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          x_wrap,
   output logic          y_wrap
);

   assign x_wrap = (x == XW'(H_PIXELS - 1));
   assign y_wrap = (y == YW'(V_PIXELS - 1));

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n || clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (x_wrap) begin
            x <= '0;
            y <= y_wrap ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/px_recirculator.sv
// Seeds the math-input FIFO with one zero word per pixel, then loops math
// results straight back while tapping each pixel off to the display writer.
module px_recirculator
   import px_recirculator_pkg::*;
#(
   parameter int H_PIXELS = DEF_H_PIXELS,
   parameter int V_PIXELS = DEF_V_PIXELS
) (
   input  logic                i_Clk,
   input  logic                i_Rst_n,
   input  logic [PX_W-1:0]     i_Px_Data,
   input  logic                i_Src_Fifo_Empty,
   output logic                o_Src_Fifo_Ack,
   output logic [PX_W-1:0]     o_Px_Data,
   input  logic                i_Dst_Fifo_Full,
   output logic                o_Dst_Fifo_Wrreq,
   input  logic                i_Disp_Ready,
   output logic                o_Disp_Valid,
   output logic [7:0]          o_Disp_Px,
   output logic [DISP_X_W-1:0] o_Disp_X,
   output logic [DISP_Y_W-1:0] o_Disp_Y,
   output logic                o_Frame_Done,
   output logic [FRAME_W-1:0]  o_Frame_Count,
   output logic [CNT_W-1:0]    o_Escaped_Count,
   output logic                o_Seeding
);

   localparam logic [CNT_W-1:0] SEED_LAST = CNT_W'(H_PIXELS * V_PIXELS - 1);

   rec_state_e          state;
   logic [CNT_W-1:0]    seed_cnt;
   logic [CNT_W-1:0]    esc_cnt;
   logic                seed_wr;
   logic                xfer;
   logic                esc;
   logic                x_wrap;
   logic                y_wrap;
   logic                frame_last;
   logic [DISP_X_W-1:0] pos_x;
   logic [DISP_Y_W-1:0] pos_y;

   // Both strobes are gated by reset so nothing reaches the FIFOs while held.
   assign seed_wr    = i_Rst_n && (state == ST_SEED) && !i_Dst_Fifo_Full;
   assign xfer       = i_Rst_n && (state == ST_RUN) && !i_Src_Fifo_Empty &&
                       !i_Dst_Fifo_Full && i_Disp_Ready;

   assign o_Dst_Fifo_Wrreq = seed_wr | xfer;
   assign o_Src_Fifo_Ack   = xfer;
   assign o_Px_Data        = (state == ST_RUN) ? i_Px_Data : '0;
   assign o_Seeding        = (state == ST_SEED);

   assign esc        = px_escaped(i_Px_Data[PX_X_LSB +: PX_FIELD_W],
                                  i_Px_Data[PX_Y_LSB +: PX_FIELD_W]);
   assign frame_last = x_wrap & y_wrap;

   px_raster_counter #(
      .H_PIXELS (H_PIXELS),
      .V_PIXELS (V_PIXELS),
      .XW       (DISP_X_W),
      .YW       (DISP_Y_W)
   ) u_raster (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .clr     (state == ST_SEED),
      .en      (xfer),
      .x       (pos_x),
      .y       (pos_y),
      .x_wrap  (x_wrap),
      .y_wrap  (y_wrap)
   );

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state           <= ST_SEED;
         seed_cnt        <= '0;
         esc_cnt         <= '0;
         o_Disp_Valid    <= 1'b0;
         o_Disp_Px       <= '0;
         o_Disp_X        <= '0;
         o_Disp_Y        <= '0;
         o_Frame_Done    <= 1'b0;
         o_Frame_Count   <= '0;
         o_Escaped_Count <= '0;
      end else begin
         o_Disp_Valid <= xfer;
         o_Frame_Done <= xfer & frame_last;
         case (state)
            ST_SEED: begin
               if (seed_wr) begin
                  if (seed_cnt == SEED_LAST) begin
                     state    <= ST_RUN;
                     seed_cnt <= '0;
                  end else begin
                     seed_cnt <= seed_cnt + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (xfer) begin
                  o_Disp_Px <= i_Px_Data[PX_VAL_MSB:PX_VAL_LSB];
                  o_Disp_X  <= pos_x;
                  o_Disp_Y  <= pos_y;
                  // Last pixel's escape status is folded into the published total.
                  if (frame_last) begin
                     o_Escaped_Count <= esc_cnt + CNT_W'(esc);
                     esc_cnt         <= '0;
                     o_Frame_Count   <= o_Frame_Count + 1'b1;
                  end else if (esc) begin
                     esc_cnt <= esc_cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_SEED;
         endcase
      end
   end

endmodule

// File: tb/tb_px_recirculator.sv
// Directed bench for px_recirculator on a reduced 8x4 raster: seeding,
// table-driven stall vectors, a full escape-counting frame and mid-frame reset.
module tb_px_recirculator;
   import px_recirculator_pkg::*;

   localparam int H     = 8;
   localparam int V     = 4;
   localparam int TOTAL = H * V;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [103:0] px_in;
   logic         empty;
   logic         ack;
   logic [103:0] px_out;
   logic         full;
   logic         wrreq;
   logic         ready;
   logic         dv;
   logic [7:0]   dpx;
   logic [9:0]   dx;
   logic [8:0]   dy;
   logic         fd;
   logic [15:0]  fc;
   logic [18:0]  ec;
   logic         seeding;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   px_recirculator #(.H_PIXELS(H), .V_PIXELS(V)) dut (
      .i_Clk            (clk),
      .i_Rst_n          (rst_n),
      .i_Px_Data        (px_in),
      .i_Src_Fifo_Empty (empty),
      .o_Src_Fifo_Ack   (ack),
      .o_Px_Data        (px_out),
      .i_Dst_Fifo_Full  (full),
      .o_Dst_Fifo_Wrreq (wrreq),
      .i_Disp_Ready     (ready),
      .o_Disp_Valid     (dv),
      .o_Disp_Px        (dpx),
      .o_Disp_X         (dx),
      .o_Disp_Y         (dy),
      .o_Frame_Done     (fd),
      .o_Frame_Count    (fc),
      .o_Escaped_Count  (ec),
      .o_Seeding        (seeding)
   );

   task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [103:0] mk(input logic [7:0] v, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] it);
      px_word_t w;
      w.val  = v;
      w.x    = x;
      w.y    = y;
      w.iter = it;
      return w;
   endfunction

   // Runs SEED to completion; checks write count, protocol and exit timing.
   task automatic seed_phase(input bit toggle, input string tag);
      int writes = 0;
      int bad    = 0;
      int c      = 0;
      bit last_wr = 1'b0;
      while (seeding && c < 400) begin
         full = toggle ? (((c / 3) % 2) == 1) : 1'b0;
         #1;
         if (wrreq !== ~full || ack !== 1'b0 || px_out !== '0) bad++;
         if (writes == TOTAL) bad++;
         last_wr = wrreq;
         if (wrreq) writes++;
         tick();
         c++;
      end
      full = 1'b0;
      chk({tag, "_writes"}, writes, TOTAL);
      chk({tag, "_protocol"}, bad, 0);
      chk({tag, "_exit_after_last"}, last_wr, 1'b1);
      chk({tag, "_seeding_low"}, seeding, 1'b0);
   endtask

   typedef struct {
      logic         empty;
      logic         full;
      logic         ready;
      logic [103:0] data;
      logic         exp_xfer;
      logic [7:0]   exp_px;
      logic [9:0]   exp_x;
      logic [8:0]   exp_y;
   } vec_t;

   vec_t         vt[8];
   logic [103:0] d;
   logic [31:0]  fx;
   logic [31:0]  fy;
   int           nst;
   int           sel;
   int           bad;

   initial begin
      vt[0] = '{1'b0, 1'b0, 1'b1, 104'h80_00000001_00000002_00000005, 1'b1, 8'h80, 10'd0, 9'd0};
      vt[1] = '{1'b1, 1'b0, 1'b1, 104'h11_00000000_00000000_00000007, 1'b0, 8'h00, 10'd0, 9'd0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 104'h11_00000000_00000000_00000007, 1'b1, 8'h11, 10'd1, 9'd0};
      vt[3] = '{1'b0, 1'b1, 1'b1, 104'h22_00000003_00000004_00000009, 1'b0, 8'h00, 10'd0, 9'd0};
      vt[4] = '{1'b0, 1'b0, 1'b0, 104'h22_00000003_00000004_00000009, 1'b0, 8'h00, 10'd0, 9'd0};
      vt[5] = '{1'b0, 1'b0, 1'b1, 104'h22_00000003_00000004_00000009, 1'b1, 8'h22, 10'd2, 9'd0};
      vt[6] = '{1'b0, 1'b0, 1'b1, 104'h33_FFFFFFFF_00000000_00000001, 1'b1, 8'h33, 10'd3, 9'd0};
      vt[7] = '{1'b1, 1'b1, 1'b0, 104'h44_00000000_00000000_00000000, 1'b0, 8'h00, 10'd0, 9'd0};

      // Reset with a non-empty source: nothing may be written or acked.
      rst_n = 1'b0;
      empty = 1'b0;
      full  = 1'b0;
      ready = 1'b1;
      px_in = mk(8'h55, 32'd1, 32'd2, 32'd3);
      tick();
      tick();
      chk("rst_wrreq", wrreq, 1'b0);
      chk("rst_ack", ack, 1'b0);
      chk("rst_seeding", seeding, 1'b1);
      chk("rst_dv", dv, 1'b0);
      chk("rst_fd", fd, 1'b0);
      chk("rst_fc", fc, 16'd0);
      chk("rst_ec", ec, 19'd0);
      chk("rst_disp", {dpx, dx, dy}, 27'd0);

      rst_n = 1'b1;
      seed_phase(1'b1, "seed_toggle");

      for (int i = 0; i < 8; i++) begin
         empty = vt[i].empty;
         full  = vt[i].full;
         ready = vt[i].ready;
         px_in = vt[i].data;
         #1;
         chk($sformatf("vec%0d_ack", i), ack, vt[i].exp_xfer);
         chk($sformatf("vec%0d_wrreq", i), wrreq, vt[i].exp_xfer);
         chk($sformatf("vec%0d_pxout", i), px_out, vt[i].data);
         tick();
         chk($sformatf("vec%0d_dv", i), dv, vt[i].exp_xfer);
         if (vt[i].exp_xfer) begin
            chk($sformatf("vec%0d_px", i), dpx, vt[i].exp_px);
            chk($sformatf("vec%0d_xy", i), {dx, dy}, {vt[i].exp_x, vt[i].exp_y});
         end
      end

      // Finish frame 0 (pixels 4..31) under random single-cause stalls.
      // Escaped: idx%3==0 (6..30) -> 9; idx%5 only sets X, so not escaped.
      bad = 0;
      for (int idx = 4; idx < TOTAL; idx++) begin
         fx = ((idx % 3) == 0 || (idx % 5) == 0) ? ESC_MARK : 32'(idx);
         fy = ((idx % 3) == 0) ? ESC_MARK : 32'd0;
         d  = mk(8'(idx + 8'h40), fx, fy, 32'(idx));
         px_in = d;
         nst = $urandom_range(0, 3);
         for (int s = 0; s < nst; s++) begin
            sel   = $urandom_range(0, 2);
            empty = (sel == 0);
            full  = (sel == 1);
            ready = (sel != 2);
            #1;
            if (ack !== 1'b0 || wrreq !== 1'b0) bad++;
            tick();
            if (dv !== 1'b0 || fd !== 1'b0) bad++;
         end
         empty = 1'b0;
         full  = 1'b0;
         ready = 1'b1;
         #1;
         chk($sformatf("feed%0d_pxout", idx), px_out, d);
         chk($sformatf("feed%0d_ack", idx), {ack, wrreq}, 2'b11);
         tick();
         chk($sformatf("feed%0d_dv", idx), dv, 1'b1);
         chk($sformatf("feed%0d_px", idx), dpx, 8'(idx + 8'h40));
         chk($sformatf("feed%0d_xy", idx), {dx, dy}, {10'(idx % H), 9'(idx / H)});
         chk($sformatf("feed%0d_fd", idx), fd, (idx == TOTAL - 1));
      end
      chk("stall_quiet", bad, 0);
      chk("frame0_escaped", ec, 19'd9);
      chk("frame0_count", fc, 16'd1);
      empty = 1'b1;
      tick();
      chk("frame_done_single", {fd, dv}, 2'b00);

      // Frame 1: stop after 20 pixels, then reset mid-frame.
      empty = 1'b0;
      for (int idx = 0; idx < 20; idx++) begin
         px_in = mk(8'(idx), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
         tick();
      end
      chk("mid_xy", {dx, dy}, {10'd3, 9'd2});
      chk("mid_dv", dv, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_strobes", {ack, wrreq}, 2'b00);
      tick();
      chk("mid_rst_seeding", seeding, 1'b1);
      chk("mid_rst_disp", {dv, fd, dpx, dx, dy}, 29'd0);
      chk("mid_rst_counts", {fc, ec}, 35'd0);
      rst_n = 1'b1;
      seed_phase(1'b0, "reseed");

      px_in = mk(8'hA5, 32'd0, 32'd0, 32'd0);
      tick();
      chk("rerun_first", {dv, dpx, dx, dy}, {1'b1, 8'hA5, 10'd0, 9'd0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1);
   end

endmodule

// File: doc/px_recirculator.md
PX_RECIRCULATOR -- requirements
Module: px_recirculator

Interface
REQ-001 SHALL have parameter H_PIXELS, default 800, pixels per line.
REQ-002 SHALL have parameter V_PIXELS, default 480, lines per frame.
REQ-003 SHALL have port i_Clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port i_Rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port i_Px_Data, input, 104, math-output FIFO word {PxVal[7:0], X[31:0], Y[31:0], Iter[31:0]}.
REQ-006 SHALL have port i_Src_Fifo_Empty, input, 1, math-output FIFO empty.
REQ-007 SHALL have port o_Src_Fifo_Ack, output, 1, show-ahead read acknowledge to math-output FIFO.
REQ-008 SHALL have port o_Px_Data, output, 104, word written to math-input FIFO.
REQ-009 SHALL have port i_Dst_Fifo_Full, input, 1, math-input FIFO full.
REQ-010 SHALL have port o_Dst_Fifo_Wrreq, output, 1, write request to math-input FIFO.
REQ-011 SHALL have port i_Disp_Ready, input, 1, display writer can accept a pixel.
REQ-012 SHALL have ports o_Disp_Valid (1), o_Disp_Px (8), o_Disp_X (10), o_Disp_Y (9), outputs, registered pixel to display writer.
REQ-013 SHALL have ports o_Frame_Done (1), o_Frame_Count (16), o_Escaped_Count (19), o_Seeding (1), outputs, status.

Function
REQ-014 SHALL implement states SEED and RUN; SEED entered on reset.
REQ-015 In SEED, o_Dst_Fifo_Wrreq SHALL equal ~i_Dst_Fifo_Full, o_Px_Data SHALL be all-zero, o_Src_Fifo_Ack SHALL be 0, o_Seeding SHALL be 1.
REQ-016 SEED SHALL count accepted writes 0..H_PIXELS*V_PIXELS-1 (19-bit counter) and move to RUN the cycle after the last accepted write.
REQ-017 In RUN, xfer = ~i_Src_Fifo_Empty & ~i_Dst_Fifo_Full & i_Disp_Ready; o_Src_Fifo_Ack and o_Dst_Fifo_Wrreq SHALL both equal xfer.
REQ-018 In RUN, o_Px_Data SHALL equal i_Px_Data combinationally (zero-latency recirculation, no modification).
REQ-019 On each xfer, the next cycle SHALL present o_Disp_Valid=1, o_Disp_Px=i_Px_Data[103:96], o_Disp_X/o_Disp_Y = current pixel position; otherwise o_Disp_Valid=0.
REQ-020 Pixel position SHALL start at (0,0) on RUN entry, advance X on xfer, wrap X at H_PIXELS-1 to 0 with Y+1, wrap Y at V_PIXELS-1 to 0.
REQ-021 A word SHALL count as escaped when X==32'hFFFFFFFF and Y==32'hFFFFFFFF; per-frame counter increments on escaped xfer.
REQ-022 On xfer of pixel (H_PIXELS-1,V_PIXELS-1): o_Escaped_Count SHALL load frame total including this pixel, per-frame counter SHALL clear, o_Frame_Count SHALL increment (wrap at 16'hFFFF to 0), o_Frame_Done SHALL pulse one cycle aligned with that pixel's o_Disp_Valid.
REQ-023 Empty, full and not-ready SHALL each independently stall with no pointer, counter or output-valid change.
REQ-024 SEED/RUN SHALL never both write in one cycle; no source read SHALL occur in SEED even if source non-empty.

Reset
REQ-025 On i_Rst_n=0 at a clock edge: state SEED, seed counter 0, position (0,0), all counters 0, o_Disp_Valid 0, o_Disp_Px/X/Y 0, o_Frame_Done 0.
REQ-026 Reset mid-frame SHALL discard progress and restart seeding; both FIFOs SHALL be cleared by the same reset at system level.
REQ-027 While i_Rst_n=0, o_Dst_Fifo_Wrreq and o_Src_Fifo_Ack SHALL be 0.

Structure
REQ-028 Pixel-word field offsets, escape marker 32'hFFFFFFFF and default frame dimensions SHALL live in the shared draw header alongside draw-mode constants.
REQ-029 Raster position counter SHALL be sub-module px_raster_counter (enable, wrap outputs), reusable by the display writer.

Verification
REQ-030 Reset, full=0 -> exactly 384000 zero writes, o_Seeding drops the cycle after write 384000, no source acks.
REQ-031 Toggle full every 3 cycles during SEED -> still exactly 384000 writes, none while full.
REQ-032 RUN, source word 104'h80_00000001_00000002_00000005 -> same word on o_Px_Data, next cycle o_Disp_Px=8'h80 at (0,0).
REQ-033 Feed 384000 words, 1000 with X=Y=FFFFFFFF -> o_Escaped_Count=1000, o_Frame_Done single pulse with (799,479), o_Frame_Count=1.
REQ-034 Random empty/full/ready stalls -> no lost/duplicated words; display sequence in raster order.
REQ-035 Reset asserted at pixel (400,200) -> outputs to reset values, seeding restarts from 0.
